// File: rtl/patch_embedding.sv
// patch_embedding
//   Linear patch projection for the ViT front end:
//     out_embed[t][e] = sum_k X[t][k]*W[k][e] + b[e]
//   All products share one signed fixed-point MAC, one product per cycle.
//   Each output element is rounded half up and narrowed to DATA_WIDTH.
//   Results are collected in an internal memory and published to
//   out_embed in one step, on the same edge that raises done.
//
// Configuration macro:
//   PATCH_EMBED_SAT_EN  defined   -> out-of-range results clamp to the signed
//                                    DATA_WIDTH limits and set sat_flag
//                       undefined -> results wrap to their low DATA_WIDTH bits,
//                                    and sat_flag is tied low
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   start      begin a projection (sampled only when idle)
//   X_in       patches, element (t,k) at flat index t*PATCH_DIM+k
//   W_in       weights, element (k,e) at flat index k*E+e
//   b_in       bias, element e at flat index e
//   busy       high while a projection is in progress
//   out_embed  result, element (t,e) at flat index t*E+e
//   out_valid  one-cycle pulse, coincident with done
//   done       one-cycle completion pulse
//   sat_flag   sticky clamp indicator for the last run
module patch_embedding #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int NUM_TOKENS = 196,
  parameter int PATCH_DIM  = 48,
  parameter int E          = 128
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic [DATA_WIDTH*NUM_TOKENS*PATCH_DIM-1:0] X_in,
  input  logic [DATA_WIDTH*PATCH_DIM*E-1:0]          W_in,
  input  logic [DATA_WIDTH*E-1:0]                    b_in,
  output logic                                    busy,
  output logic [DATA_WIDTH*NUM_TOKENS*E-1:0]       out_embed,
  output logic                                    out_valid,
  output logic                                    done,
  output logic                                    sat_flag
);

  localparam int ACC_W = 2*DATA_WIDTH + $clog2(PATCH_DIM+1);
  localparam int OUT_W = DATA_WIDTH*NUM_TOKENS*E;
  localparam logic signed [ACC_W-1:0] ROUND_K =
    {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_BITS-1);

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  state_t r_state;
  state_t w_nextState;

  // Running flat indices avoid multipliers in the address path:
  // r_xBase = t*PATCH_DIM, r_wIdx = k*E+e, r_oIdx = t*E+e.
  logic [31:0] r_t, r_e, r_k;
  logic [31:0] r_xBase, r_wIdx, r_oIdx;
  logic signed [ACC_W-1:0] r_acc;
  logic [OUT_W-1:0] r_mem;

  logic w_lastK, w_lastE, w_lastT;
  logic [31:0] w_biasIdx;
  logic signed [DATA_WIDTH-1:0] w_x, w_w, w_bias;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_W-1:0] w_prodExt, w_biasAcc, w_sum, w_round;
  logic [DATA_WIDTH-1:0] w_result;

  assign w_lastK = (r_k == 32'(PATCH_DIM-1));
  assign w_lastE = (r_e == 32'(E-1));
  assign w_lastT = (r_t == 32'(NUM_TOKENS-1));

  assign w_x    = X_in[(r_xBase + r_k)*DATA_WIDTH +: DATA_WIDTH];
  assign w_w    = W_in[r_wIdx*DATA_WIDTH +: DATA_WIDTH];
  assign w_prod = w_x * w_w;
  assign w_prodExt = {{(ACC_W-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};

  // The accumulator is seeded with the bias of the element about to be
  // computed: b[0] on start, otherwise the bias of the next e after a write.
  assign w_biasIdx = (r_state == IDLE || w_lastE) ? 32'd0 : (r_e + 32'd1);
  assign w_bias    = b_in[w_biasIdx*DATA_WIDTH +: DATA_WIDTH];
  assign w_biasAcc = {{(ACC_W-DATA_WIDTH){w_bias[DATA_WIDTH-1]}}, w_bias} << FRAC_BITS;

  assign w_sum   = r_acc + ROUND_K;
  assign w_round = w_sum >>> FRAC_BITS;

`ifdef PATCH_EMBED_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic w_satHi, w_satLo;
  logic r_sat;

  assign w_satHi  = (w_round > SAT_MAX);
  assign w_satLo  = (w_round < SAT_MIN);
  assign w_result = w_satHi ? SAT_MAX[DATA_WIDTH-1:0] :
                    w_satLo ? SAT_MIN[DATA_WIDTH-1:0] :
                              w_round[DATA_WIDTH-1:0];
  assign sat_flag = r_sat;

  // Sticky clamp flag: cleared when a run is accepted, set by any clamped write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_sat <= 1'b0;
    end else if (r_state == WRITE && (w_satHi || w_satLo)) begin
      r_sat <= 1'b1;
    end
  end
`else
  logic w_unusedRoundBits;

  assign w_result = w_round[DATA_WIDTH-1:0];
  assign w_unusedRoundBits = ^w_round[ACC_W-1:DATA_WIDTH];
  assign sat_flag = 1'b0;
`endif

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = MAC;
      MAC:     if (w_lastK) w_nextState = WRITE;
      WRITE:   w_nextState = (w_lastE && w_lastT) ? DONE : MAC;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t       <= '0;
      r_e       <= '0;
      r_k       <= '0;
      r_xBase   <= '0;
      r_wIdx    <= '0;
      r_oIdx    <= '0;
      r_acc     <= '0;
      r_mem     <= '0;
      out_embed <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      done      <= 1'b0;
      out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_t     <= '0;
            r_e     <= '0;
            r_k     <= '0;
            r_xBase <= '0;
            r_wIdx  <= '0;
            r_oIdx  <= '0;
            r_acc   <= w_biasAcc;
          end
        end
        MAC: begin
          r_acc  <= r_acc + w_prodExt;
          r_k    <= r_k + 32'd1;
          r_wIdx <= r_wIdx + 32'(E);
        end
        WRITE: begin
          r_mem[r_oIdx*DATA_WIDTH +: DATA_WIDTH] <= w_result;
          r_oIdx <= r_oIdx + 32'd1;
          r_k    <= '0;
          r_acc  <= w_biasAcc;
          if (w_lastE) begin
            r_e     <= '0;
            r_t     <= r_t + 32'd1;
            r_xBase <= r_xBase + 32'(PATCH_DIM);
            r_wIdx  <= '0;
          end else begin
            r_e    <= r_e + 32'd1;
            r_wIdx <= r_e + 32'd1;
          end
        end
        DONE: begin
          out_embed <= r_mem;
          done      <= 1'b1;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
